// File: rtl/hdmi_video_timing_ctrl_if.sv
// Pixel stream handshake between an upstream pixel source and the video timing controller.
// The source drives pix_data and pix_valid; the timing controller drives pix_ready.
interface hdmi_video_timing_ctrl_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input  pix_ready);
  modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface

// File: rtl/hdmi_video_timing_ctrl.sv
// Raster generator and output sequencer for the three TMDS channel encoders of one HDMI/DVI port.
// All encoder-facing outputs are registered together, one cycle behind the raster counters.
module hdmi_video_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  hdmi_video_timing_ctrl_if.slave         pix,
  output logic                            disp_en,
  output logic [1:0]                      ctrl_b,
  output logic [1:0]                      ctrl_g,
  output logic [1:0]                      ctrl_r,
  output logic [7:0]                      data_r,
  output logic [7:0]                      data_g,
  output logic [7:0]                      data_b,
  output logic                            frame_start,
  output logic                            underflow,
  output logic [11:0]                     h_cnt,
  output logic [10:0]                     v_cnt
);

  localparam int unsigned HW       = 12;
  localparam int unsigned VW       = 11;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Totals must be non-zero and representable by the position counters.
  if (H_TOTAL == 0 || H_TOTAL > (1 << HW)) begin : g_h_total_chk
    $error("hdmi_video_timing_ctrl: H_TOTAL %0d does not fit h_cnt", H_TOTAL);
  end
  if (V_TOTAL == 0 || V_TOTAL > (1 << VW)) begin : g_v_total_chk
    $error("hdmi_video_timing_ctrl: V_TOTAL %0d does not fit v_cnt", V_TOTAL);
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t state, state_nxt;
  logic   run_c, active_c, hs_c, vs_c, first_c, xfer_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: enable alone decides, so a drop aborts immediately
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable)  state_nxt = S_RUN;
      S_RUN:   if (!enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Region decode and handshake, gated by RUN so IDLE is always blanking
  always_comb begin
    run_c         = (state == S_RUN);
    active_c      = run_c && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    hs_c          = run_c && (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    vs_c          = run_c && (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    first_c       = run_c && (h_cnt == '0) && (v_cnt == '0);
    xfer_c        = active_c && pix.pix_valid;
    pix.pix_ready = active_c;
  end

  // Raster counters; held at the origin whenever not running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run_c && enable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Encoder-facing output stage, one cycle behind the counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_en     <= 1'b0;
      ctrl_b      <= {~VS_POL, ~HS_POL};
      data_r      <= '0;
      data_g      <= '0;
      data_b      <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      disp_en     <= active_c;
      ctrl_b      <= {vs_c ? VS_POL : ~VS_POL, hs_c ? HS_POL : ~HS_POL};
      data_r      <= xfer_c ? pix.pix_data[23:16] : 8'd0;
      data_g      <= xfer_c ? pix.pix_data[15:8]  : 8'd0;
      data_b      <= xfer_c ? pix.pix_data[7:0]   : 8'd0;
      frame_start <= first_c;
      underflow   <= active_c && !pix.pix_valid;
    end
  end

  assign ctrl_g = 2'b00;
  assign ctrl_r = 2'b00;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench for hdmi_video_timing_ctrl: two small-raster instances (default and inverted sync polarity)
// share stimulus and are checked every cycle against a time-index model of the raster.
module tb_hdmi_video_timing_ctrl;
  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdmi_video_timing_ctrl_if if0 ();
  hdmi_video_timing_ctrl_if if1 ();
  assign if0.pix_data  = pix_data;
  assign if0.pix_valid = pix_valid;
  assign if1.pix_data  = pix_data;
  assign if1.pix_valid = pix_valid;

  logic        de0, fs0, uf0, de1, fs1, uf1;
  logic [1:0]  cb0, cg0, cr0, cb1, cg1, cr1;
  logic [7:0]  dr0, dg0, db0, dr1, dg1, db1;
  logic [11:0] h0, h1;
  logic [10:0] v0, v1;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .pix(if0),
    .disp_en(de0), .ctrl_b(cb0), .ctrl_g(cg0), .ctrl_r(cr0),
    .data_r(dr0), .data_g(dg0), .data_b(db0),
    .frame_start(fs0), .underflow(uf0), .h_cnt(h0), .v_cnt(v0)
  );

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .pix(if1),
    .disp_en(de1), .ctrl_b(cb1), .ctrl_g(cg1), .ctrl_r(cr1),
    .data_r(dr1), .data_g(dg1), .data_b(db1),
    .frame_start(fs1), .underflow(uf1), .h_cnt(h1), .v_cnt(v1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the raster is a pure function of cycles elapsed since the run started.
  logic        m_run = 1'b0;
  int          m_t = 0;
  int          mh, mv;
  logic        m_act;
  logic        e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0, e_uf = 1'b0;
  logic [23:0] e_data = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_run = 1'b0; m_t = 0;
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_uf = 1'b0; e_data = '0;
    end else begin
      mh     = m_run ? m_t % HT : 0;
      mv     = m_run ? (m_t / HT) % VT : 0;
      m_act  = m_run && mh < HA && mv < VA;
      e_de   = m_act;
      e_hs   = m_run && mh >= HA + HF && mh < HA + HF + HS;
      e_vs   = m_run && mv >= VA + VF && mv < VA + VF + VS;
      e_fs   = m_run && mh == 0 && mv == 0;
      e_uf   = m_act && !pix_valid;
      e_data = (m_act && pix_valid) ? pix_data : 24'd0;
      if (enable) begin
        m_t   = m_run ? m_t + 1 : 0;
        m_run = 1'b1;
      end else begin
        m_run = 1'b0;
        m_t   = 0;
      end
    end
  end

  logic        x_de, x_hs, x_vs, x_fs, x_uf, x_rdy;
  logic [23:0] x_data;
  int          x_h, x_v;

  task automatic cmp_dut(input string tag, input bit pol, input logic de, input logic [1:0] cb,
                         input logic [1:0] cg, input logic [1:0] cr, input logic [23:0] rgb,
                         input logic fs, input logic uf, input logic [11:0] h,
                         input logic [10:0] v, input logic rdy);
    chk({tag, "_disp_en"}, 32'(de), 32'(x_de));
    chk({tag, "_ctrl_b"}, 32'(cb), 32'({x_vs ? pol : ~pol, x_hs ? pol : ~pol}));
    chk({tag, "_ctrl_gr"}, 32'({cg, cr}), 32'd0);
    chk({tag, "_data"}, 32'(rgb), 32'(x_data));
    chk({tag, "_frame_start"}, 32'(fs), 32'(x_fs));
    chk({tag, "_underflow"}, 32'(uf), 32'(x_uf));
    chk({tag, "_h_cnt"}, 32'(h), x_h);
    chk({tag, "_v_cnt"}, 32'(v), x_v);
    chk({tag, "_pix_ready"}, 32'(rdy), 32'(x_rdy));
  endtask

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      if (!reset) begin
        x_de = 1'b0; x_hs = 1'b0; x_vs = 1'b0; x_fs = 1'b0; x_uf = 1'b0; x_data = '0;
        x_h = 0; x_v = 0; x_rdy = 1'b0;
      end else begin
        x_de = e_de; x_hs = e_hs; x_vs = e_vs; x_fs = e_fs; x_uf = e_uf; x_data = e_data;
        x_h   = m_run ? m_t % HT : 0;
        x_v   = m_run ? (m_t / HT) % VT : 0;
        x_rdy = m_run && x_h < HA && x_v < VA;
      end
      cmp_dut("d0", 1'b0, de0, cb0, cg0, cr0, {dr0, dg0, db0}, fs0, uf0, h0, v0, if0.pix_ready);
      cmp_dut("d1", 1'b1, de1, cb1, cg1, cr1, {dr1, dg1, db1}, fs1, uf1, h1, v1, if1.pix_ready);
    end
  end

  // Source: incrementing pixels (optionally dropping pixel (2,1)) or random data/valid
  int   mode = 0;
  logic drop_en = 1'b0;
  logic xf_n = 1'b0;

  always @(negedge clk) xf_n = if0.pix_ready && pix_valid;

  always @(posedge clk) begin
    #1;
    if (mode == 0) begin
      if (xf_n) pix_data = pix_data + 24'd1;
      pix_valid = !(drop_en && h0 == 12'd2 && v0 == 11'd1);
    end else begin
      pix_valid = ($urandom_range(0, 9) != 0);
      pix_data  = 24'($urandom);
    end
  end

  task automatic wait_fs();
    int n = 0;
    @(negedge clk);
    while (!fs0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frame_start_in_budget", 32'(n < 200), 32'd1);
  endtask

  // Tally one 40-cycle frame window starting at the current negedge
  task automatic count_frame(output int fs, output int de, output int hsl0, output int hsh1,
                             output int vsl0, output int xf, output int uf);
    fs = 0; de = 0; hsl0 = 0; hsh1 = 0; vsl0 = 0; xf = 0; uf = 0;
    for (int k = 0; k < int'(HT * VT); k++) begin
      if (k > 0) @(negedge clk);
      fs   += int'(fs0);
      de   += int'(de0);
      hsl0 += int'(cb0[0] == 1'b0);
      hsh1 += int'(cb1[0] == 1'b1);
      vsl0 += int'(cb0[1] == 1'b0);
      xf   += int'(if0.pix_ready && pix_valid);
      uf   += int'(uf0);
    end
  endtask

  int c_fs, c_de, c_hsl, c_hsh, c_vsl, c_xf, c_uf;
  int off_cnt;
  int n;

  initial begin
    reset = 1'b1; enable = 1'b1; pix_valid = 1'b1; pix_data = 24'd0;
    #2 reset = 1'b0;
    #1 started = 1'b1;

    // Reset held with enable and valid high
    repeat (3) @(negedge clk);
    chk("rst_ctrl_b_d0", 32'(cb0), 32'h3);
    chk("rst_ctrl_b_d1", 32'(cb1), 32'h0);
    chk("rst_pix_ready", 32'(if0.pix_ready), 32'd0);
    chk("rst_disp_en", 32'(de0), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Full frame, always valid
    wait_fs();
    count_frame(c_fs, c_de, c_hsl, c_hsh, c_vsl, c_xf, c_uf);
    chk("frame_fs_count", c_fs, 1);
    chk("frame_de_cycles", c_de, 8);
    chk("frame_hs_low_d0", c_hsl, 10);
    chk("frame_hs_high_d1", c_hsh, 10);
    chk("frame_vs_low_d0", c_vsl, 8);
    chk("frame_transfers", c_xf, 8);
    chk("frame_underflows", c_uf, 0);
    @(negedge clk);
    chk("frame_period_40", 32'(fs0), 32'd1);

    // Underflow on pixel (2,1)
    drop_en = 1'b1;
    count_frame(c_fs, c_de, c_hsl, c_hsh, c_vsl, c_xf, c_uf);
    drop_en = 1'b0;
    chk("uf_de_cycles", c_de, 8);
    chk("uf_pulses", c_uf, 1);
    chk("uf_transfers", c_xf, 7);
    @(negedge clk);
    chk("uf_period_40", 32'(fs0), 32'd1);

    // Abort at (3,0), restart 3 cycles later
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(h0 == 12'd3 && v0 == 11'd0) && n < 100);
    chk("abort_reach_3_0", 32'(n < 100), 32'd1);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_last_pixel_de", 32'(de0), 32'd1);
    chk("abort_h_cnt", 32'(h0), 32'd0);
    chk("abort_pix_ready", 32'(if0.pix_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_blank_de", 32'(de0), 32'd0);
    chk("abort_blank_ctrl_d0", 32'(cb0), 32'h3);
    chk("abort_blank_ctrl_d1", 32'(cb1), 32'h0);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_h_cnt", 32'(h0), 32'd0);
    chk("restart_pix_ready", 32'(if0.pix_ready), 32'd1);
    chk("restart_fs_not_yet", 32'(fs0), 32'd0);
    @(negedge clk);
    chk("restart_frame_start", 32'(fs0), 32'd1);
    chk("restart_disp_en", 32'(de0), 32'd1);

    // Random source, random enable drops, one mid-frame reset
    mode = 1;
    off_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (i == 700) reset = 1'b0;
      if (i == 703) reset = 1'b1;
      if (off_cnt > 0) begin
        off_cnt--;
        if (off_cnt == 0) enable = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        enable  = 1'b0;
        off_cnt = $urandom_range(1, 4);
      end
    end
    enable = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
